// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer and the external ALU.
//   opcode_e : 4-bit opcodes; 0x0-0xA go to the ALU, 0xB-0xF are handled
//              by the sequencer itself.
//   state_e  : sequencer state encoding.
//   instr_t  : 16-bit program word layout.
//   FLAG_*   : bit positions of {Z,N,C,V} in the flags nibble.
package alu_pkg;

  localparam int unsigned DATA_W    = 4;
  localparam int unsigned REG_COUNT = 4;

  typedef enum logic [3:0] {
    OP_ADD    = 4'h0,
    OP_SUB    = 4'h1,
    OP_AND    = 4'h2,
    OP_OR     = 4'h3,
    OP_XOR    = 4'h4,
    OP_NAND   = 4'h5,
    OP_NOR    = 4'h6,
    OP_XNOR   = 4'h7,
    OP_NOT    = 4'h8,
    OP_LSHIFT = 4'h9,
    OP_RSHIFT = 4'hA,
    OP_LDI    = 4'hB,
    OP_BZ     = 4'hC,
    OP_JMP    = 4'hD,
    OP_NOP    = 4'hE,
    OP_HALT   = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef struct packed {
    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] ra;
    logic       imm_sel;
    logic       rsvd;
    logic [1:0] rb;
    logic [3:0] imm;
  } instr_t;

  // Opcodes up to RSHIFT are executed by the external ALU.
  function automatic logic is_alu_op(input logic [3:0] op);
    return op <= OP_RSHIFT;
  endfunction

endpackage

// File: rtl/sequencer_regfile.sv
// Four 4-bit general registers for the ALU sequencer.
//   clk, rst            : clock, asynchronous active-high reset (clears all)
//   we, waddr, wdata    : single write port, written on the rising edge
//   raddr_a / rdata_a   : operand A read port (combinational)
//   raddr_b / rdata_b   : operand B read port (combinational)
//   dbg_addr / dbg_data : debug read port (combinational); a register written
//                         this cycle still reads its old value.
module sequencer_regfile
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [1:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [1:0]        raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [1:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs [REG_COUNT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a  = regs[raddr_a];
  assign rdata_b  = regs[raddr_b];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer that fetches 16-bit words from a combinational ROM
// and drives an external 4-bit ALU.
//   iClk, iReset        : clock, asynchronous active-high reset
//   iStart              : run request, honoured only in IDLE or HALT
//   ovPC / ivInstrWord  : program address and the word at that address
//   ovInstruccion, ovRegistroA, ovRegistroB : ALU opcode/operands, nonzero
//                         only while an ALU instruction is in write-back
//   ivResultado, ivFlags: ALU result and {Z,N,C,V}
//   ovFlagsReg          : flags captured at the last ALU write-back
//   ivRegSel / ovRegData: debug register read
//   oBusy               : high in FETCH, EXEC, WB
//   oDone               : one-cycle pulse on entry to HALT
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 4
) (
  input  logic                iClk,
  input  logic                iReset,
  input  logic                iStart,
  output logic [PC_WIDTH-1:0] ovPC,
  input  logic [15:0]         ivInstrWord,
  output logic [3:0]          ovInstruccion,
  output logic [3:0]          ovRegistroA,
  output logic [3:0]          ovRegistroB,
  input  logic [3:0]          ivResultado,
  input  logic [3:0]          ivFlags,
  output logic [3:0]          ovFlagsReg,
  input  logic [1:0]          ivRegSel,
  output logic [3:0]          ovRegData,
  output logic                oBusy,
  output logic                oDone
);

  state_e              state, state_n;
  logic [PC_WIDTH-1:0] pc, pc_n, pc_inc, pc_target;
  instr_t              ir, ir_n;
  logic [3:0]          flags, flags_n;
  logic [3:0]          alu_op, alu_op_n;
  logic [3:0]          opa, opa_n;
  logic [3:0]          opb, opb_n;
  logic                done, done_n;

  logic                rf_we;
  logic [3:0]          rf_wdata;
  logic [3:0]          rdata_a, rdata_b;

  logic                unused_rsvd;
  assign unused_rsvd = ir.rsvd;

  assign pc_inc    = pc + PC_WIDTH'(1);
  assign pc_target = PC_WIDTH'(ir.imm);

  sequencer_regfile u_regfile (
    .clk      (iClk),
    .rst      (iReset),
    .we       (rf_we),
    .waddr    (ir.rd),
    .wdata    (rf_wdata),
    .raddr_a  (ir.ra),
    .rdata_a  (rdata_a),
    .raddr_b  (ir.rb),
    .rdata_b  (rdata_b),
    .dbg_addr (ivRegSel),
    .dbg_data (ovRegData)
  );

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state  <= ST_IDLE;
      pc     <= '0;
      ir     <= '0;
      flags  <= '0;
      alu_op <= '0;
      opa    <= '0;
      opb    <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      ir     <= ir_n;
      flags  <= flags_n;
      alu_op <= alu_op_n;
      opa    <= opa_n;
      opb    <= opb_n;
      done   <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    ir_n     = ir;
    flags_n  = flags;
    alu_op_n = alu_op;
    opa_n    = opa;
    opb_n    = opb;
    done_n   = 1'b0;
    rf_we    = 1'b0;
    rf_wdata = ir.imm;

    case (state)
      ST_IDLE, ST_HALT: begin
        if (iStart) begin
          state_n = ST_FETCH;
          pc_n    = '0;
        end
      end

      ST_FETCH: begin
        ir_n    = instr_t'(ivInstrWord);
        state_n = ST_EXEC;
      end

      ST_EXEC: begin
        if (is_alu_op(ir.op)) begin
          // Operands are registered here so they stay stable through WB.
          alu_op_n = ir.op;
          opa_n    = rdata_a;
          opb_n    = ir.imm_sel ? ir.imm : rdata_b;
          state_n  = ST_WB;
        end else begin
          state_n = ST_FETCH;
          pc_n    = pc_inc;
          case (ir.op)
            OP_LDI: rf_we = 1'b1;
            OP_BZ: begin
              if (flags[FLAG_Z]) begin
                pc_n = pc_target;
              end
            end
            OP_JMP: pc_n = pc_target;
            OP_HALT: begin
              pc_n    = pc;
              state_n = ST_HALT;
              done_n  = 1'b1;
            end
            default: ;
          endcase
        end
      end

      ST_WB: begin
        rf_we    = 1'b1;
        rf_wdata = ivResultado;
        flags_n  = ivFlags;
        pc_n     = pc_inc;
        state_n  = ST_FETCH;
        alu_op_n = '0;
        opa_n    = '0;
        opb_n    = '0;
      end

      default: state_n = ST_IDLE;
    endcase
  end

  assign ovPC          = pc;
  assign ovInstruccion = alu_op;
  assign ovRegistroA   = opa;
  assign ovRegistroB   = opb;
  assign ovFlagsReg    = flags;
  assign oDone         = done;
  assign oBusy         = (state == ST_FETCH) || (state == ST_EXEC) || (state == ST_WB);

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a behavioural ALU answers the
// DUT's ALU port, a program interpreter predicts the architectural state at
// each HALT, and a monitor compares it whenever oDone pulses.
module tb_alu_sequencer;

  localparam int unsigned PCW   = 4;
  localparam int          PSIZE = 1 << PCW;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [PCW-1:0] pc;
  logic [15:0]    instr;
  logic [3:0]     alu_op, opa, opb, ares, aflags, flags, regdata;
  logic [1:0]     regsel = 2'd0;
  logic           busy, done;

  logic [15:0]    prog [PSIZE];
  logic [3:0]     m_regs [4];
  logic [3:0]     m_flags;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int cyc = 0;

  typedef struct packed {
    logic [15:0] regs;
    logic [3:0]  flags;
    logic [3:0]  hpc;
    logic [31:0] due;
  } exp_t;

  exp_t expq [$];

  alu_sequencer #(.PC_WIDTH(PCW)) dut (
    .iClk          (clk),
    .iReset        (rst),
    .iStart        (start),
    .ovPC          (pc),
    .ivInstrWord   (instr),
    .ovInstruccion (alu_op),
    .ovRegistroA   (opa),
    .ovRegistroB   (opb),
    .ivResultado   (ares),
    .ivFlags       (aflags),
    .ovFlagsReg    (flags),
    .ivRegSel      (regsel),
    .ovRegData     (regdata),
    .oBusy         (busy),
    .oDone         (done)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign instr = prog[pc];

  // Reference ALU in plain integer arithmetic: returns {Z,N,C,V, result}.
  function automatic logic [7:0] alu_ref(input int op, input int a, input int b);
    int r, sa, sb, sr;
    bit c, v;
    logic [3:0] f, res;
    sa = (a > 7) ? a - 16 : a;
    sb = (b > 7) ? b - 16 : b;
    c = 0; v = 0; r = 0;
    case (op)
      0:  begin r = a + b; c = (r > 15); sr = sa + sb; v = (sr > 7) || (sr < -8); end
      1:  begin r = a - b; c = (a < b);  sr = sa - sb; v = (sr > 7) || (sr < -8); end
      2:  r = a & b;
      3:  r = a | b;
      4:  r = a ^ b;
      5:  r = ~(a & b);
      6:  r = ~(a | b);
      7:  r = ~(a ^ b);
      8:  r = ~a;
      9:  begin r = a * 2; c = (a > 7); end
      10: begin r = a / 2; c = (a % 2) == 1; end
      default: r = 0;
    endcase
    r = r & 15;
    res = 4'(r);
    f = {r == 0, r > 7, c, v};
    return {f, res};
  endfunction

  always_comb {aflags, ares} = alu_ref(int'(alu_op), int'(opa), int'(opb));

  function automatic logic [15:0] enc(input int op, input int rd, input int ra,
                                     input int isel, input int rb, input int imm);
    return {op[3:0], rd[1:0], ra[1:0], isel[0], 1'b0, rb[1:0], imm[3:0]};
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Interprets the program from address 0 using the model state; commits the
  // final state only when the program halts and commit is set.
  task automatic model_exec(input bit commit, output bit ok, output int lat, output int hpc);
    logic [3:0] r [4];
    logic [3:0] f;
    logic [7:0] res;
    logic [15:0] w;
    int p, op, rd, ra, rb, imm;
    r = m_regs; f = m_flags; p = 0; lat = 0; hpc = 0; ok = 0;
    for (int s = 0; s < 150; s++) begin
      w = prog[p];
      op = int'(w[15:12]); rd = int'(w[11:10]); ra = int'(w[9:8]);
      rb = int'(w[5:4]); imm = int'(w[3:0]);
      if (op <= 10) begin
        res = alu_ref(op, int'(r[ra]), w[7] ? imm : int'(r[rb]));
        r[rd] = res[3:0]; f = res[7:4]; p = (p + 1) % PSIZE; lat += 3;
      end else if (op == 11) begin
        r[rd] = 4'(imm); p = (p + 1) % PSIZE; lat += 2;
      end else if (op == 12) begin
        p = f[3] ? imm % PSIZE : (p + 1) % PSIZE; lat += 2;
      end else if (op == 13) begin
        p = imm % PSIZE; lat += 2;
      end else if (op == 14) begin
        p = (p + 1) % PSIZE; lat += 2;
      end else begin
        lat += 2; hpc = p; ok = 1;
        break;
      end
    end
    if (ok && commit) begin
      m_regs = r;
      m_flags = f;
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < PSIZE; i++) prog[i] = enc(14, 0, 0, 0, 0, 0);
  endtask

  task automatic run_prog(input bit noisy);
    bit ok, got;
    int lat, hpc, d0;
    exp_t e;
    model_exec(1'b1, ok, lat, hpc);
    if (!ok) begin
      errors++;
      $display("FAIL model_halt program does not reach HALT");
      return;
    end
    @(negedge clk);
    e.regs  = {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
    e.flags = m_flags;
    e.hpc   = 4'(hpc);
    e.due   = 32'(cyc + 1 + lat);
    expq.push_back(e);
    d0 = done_seen;
    start = 1'b1;
    got = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      // Stray run requests while busy must be ignored.
      start = noisy && busy && ($urandom_range(3) == 0);
      #8;
      if (done_seen != d0) begin
        got = 1;
        break;
      end
    end
    start = 1'b0;
    check("done_timeout", longint'(got), 1);
  endtask

  task automatic gen_random();
    bit ok;
    int lat, hpc;
    for (int t = 0; t < 50; t++) begin
      for (int i = 0; i < PSIZE; i++) prog[i] = 16'($urandom_range(0, 65535));
      prog[$urandom_range(0, PSIZE - 1)] = enc(15, 0, 0, 0, 0, 0);
      model_exec(1'b0, ok, lat, hpc);
      if (ok) return;
    end
    clear_prog();
    prog[PSIZE - 1] = enc(15, 0, 0, 0, 0, 0);
  endtask

  // Monitor: on every HALT entry compare the DUT against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done oDone pulsed with no pending program");
        end else begin
          e = expq.pop_front();
          check("done_cycle", cyc, longint'(e.due));
          check("halt_pc", pc, e.hpc);
          check("flags", flags, e.flags);
          check("halt_busy", busy, 0);
          check("halt_alu_op", {alu_op, opa, opb}, 0);
          for (int i = 0; i < 4; i++) begin
            regsel = 2'(i);
            #1;
            check($sformatf("reg%0d", i), regdata, e.regs[i*4 +: 4]);
          end
        end
        done_seen++;
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    m_flags = '0;
    clear_prog();
    repeat (3) @(negedge clk);
    check("rst_pc", pc, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_opa", opa, 0);
    check("rst_opb", opb, 0);
    check("rst_flags", flags, 0);
    rst = 1'b0;

    // JMP to the last word, NOP there wraps PC to 0, BZ then taken to HALT.
    clear_prog();
    prog[0]  = enc(12, 0, 0, 0, 0, 5);
    prog[1]  = enc(4, 0, 0, 0, 0, 0);
    prog[2]  = enc(13, 0, 0, 0, 0, 15);
    prog[5]  = enc(15, 0, 0, 0, 0, 0);
    prog[15] = enc(14, 0, 0, 0, 0, 0);
    run_prog(1'b0);

    // 7 + 9 wraps to 0 with carry.
    clear_prog();
    prog[0] = enc(11, 0, 0, 0, 0, 7);
    prog[1] = enc(11, 1, 0, 0, 0, 9);
    prog[2] = enc(0, 2, 0, 0, 1, 0);
    prog[3] = enc(15, 0, 0, 0, 0, 0);
    run_prog(1'b0);

    // 3 - #5 borrows.
    clear_prog();
    prog[0] = enc(11, 0, 0, 0, 0, 3);
    prog[1] = enc(1, 1, 0, 1, 0, 5);
    prog[2] = enc(15, 0, 0, 0, 0, 0);
    run_prog(1'b0);

    // BZ taken on Z=1.
    clear_prog();
    prog[0] = enc(4, 3, 3, 0, 3, 0);
    prog[1] = enc(12, 0, 0, 0, 0, 6);
    prog[2] = enc(15, 0, 0, 0, 0, 0);
    prog[6] = enc(15, 0, 0, 0, 0, 0);
    run_prog(1'b0);

    // BZ falls through on Z=0.
    clear_prog();
    prog[0] = enc(11, 0, 0, 0, 0, 1);
    prog[1] = enc(3, 1, 0, 0, 0, 0);
    prog[2] = enc(12, 0, 0, 0, 0, 6);
    prog[3] = enc(15, 0, 0, 0, 0, 0);
    prog[6] = enc(15, 0, 0, 0, 0, 0);
    run_prog(1'b0);

    // Reset during the write-back of ADD.
    clear_prog();
    prog[0] = enc(11, 0, 0, 0, 0, 7);
    prog[1] = enc(11, 1, 0, 0, 0, 9);
    prog[2] = enc(0, 2, 0, 0, 1, 0);
    prog[3] = enc(15, 0, 0, 0, 0, 0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("exec_opa_idle", opa, 0);
    check("exec_busy", busy, 1);
    @(negedge clk);
    check("wb_opa", opa, 7);
    check("wb_opb", opb, 9);
    check("wb_pc", pc, 2);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_pc", pc, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_flags", flags, 0);
    check("mid_rst_alu", {alu_op, opa, opb}, 0);
    check("mid_rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    m_flags = '0;

    // Random programs back to back; registers and flags carry across restarts.
    for (int n = 0; n < 25; n++) begin
      gen_random();
      run_prog(1'b1);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter PC_WIDTH, default 4, program-counter width; program space is 2^PC_WIDTH words.
REQ-002 iClk  input  1  sole clock; all state updates on rising edge.
REQ-003 iReset  input  1  reset, asynchronous and active-high.
REQ-004 iStart  input  1  run request; sampled only in IDLE or HALT.
REQ-005 ovPC  output  PC_WIDTH  program-memory address (combinational-read ROM).
REQ-006 ivInstrWord  input  16  program word at ovPC, valid same cycle.
REQ-007 ovInstruccion  output  4  opcode driven to the ALU.
REQ-008 ovRegistroA  output  4  ALU operand A.
REQ-009 ovRegistroB  output  4  ALU operand B.
REQ-010 ivResultado  input  4  ALU result.
REQ-011 ivFlags  input  4  ALU flags {Z,N,C,V} at bits [3:0].
REQ-012 ovFlagsReg  output  4  last captured ALU flags.
REQ-013 ivRegSel / ovRegData  input 2 / output 4  debug register read port, combinational.
REQ-014 oBusy  output  1  high in FETCH, EXEC, WB.
REQ-015 oDone  output  1  one-cycle pulse on entry to HALT.

Function
REQ-016 Word format: [15:12] op, [11:10] rd, [9:8] ra, [7] imm-select, [5:4] rb, [3:0] imm.
REQ-017 Ops 0x0-0xA are ALU ops (ADD SUB AND OR XOR NAND NOR XNOR NOT LSHIFT RSHIFT); 0xB LDI rd<=imm; 0xC BZ: PC<=imm if ovFlagsReg[3]; 0xD JMP PC<=imm; 0xE NOP; 0xF HALT.
REQ-018 States IDLE, FETCH, EXEC, WB, HALT; IDLE/HALT --iStart--> FETCH with PC<=0; registers and flags preserved on restart.
REQ-019 FETCH latches ivInstrWord into the instruction register, then -> EXEC.
REQ-020 EXEC, ALU op: ovInstruccion<=op, ovRegistroA<=R[ra], ovRegistroB<=imm-select ? imm : R[rb], registered; -> WB.
REQ-021 WB: R[rd]<=ivResultado, ovFlagsReg<=ivFlags, PC<=PC+1, -> FETCH; ALU outputs held stable through WB.
REQ-022 EXEC, non-ALU op: LDI/NOP/BZ-not-taken PC<=PC+1; BZ-taken/JMP PC<=imm[PC_WIDTH-1:0]; -> FETCH; HALT -> HALT, PC unchanged.
REQ-023 Latency: ALU op 3 cycles, other ops 2 cycles; flags change only in WB.
REQ-024 PC increment wraps modulo 2^PC_WIDTH (max -> 0).
REQ-025 iStart while oBusy ignored; held iStart in HALT restarts once per HALT entry.
REQ-026 Debug read of a register written the same cycle returns the old value.
REQ-027 ALU output ports return to 0 outside EXEC/WB.

Reset
REQ-028 On iReset: state IDLE, PC 0, R0-R3 0, ovFlagsReg 0, ovInstruccion/ovRegistroA/ovRegistroB 0, oBusy 0, oDone 0.
REQ-029 iReset asserted mid-instruction aborts it with no register or flag write.

Structure
REQ-030 Shared package alu_pkg holds the 4-bit opcode constants (shared with the ALU), sequencer op codes 0xB-0xF, state encoding, and flag bit indices Z=3, N=2, C=1, V=0.
REQ-031 Single sub-module sequencer_regfile: 4x4 registers, one write port, two read ports plus debug read.

Verification
REQ-032 Program LDI r0,7; LDI r1,9; ADD r2,r0,r1; HALT with real ALU -> R2=0, ovFlagsReg=4'b1010, oDone pulses 9 cycles after first FETCH.
REQ-033 LDI r0,3; SUB r1,r0,#5; HALT -> R1=4'b1110, ovFlagsReg=4'b0110.
REQ-034 Flags Z=1 then BZ 6 -> next ovPC=6; Z=0 -> next ovPC=PC+1.
REQ-035 JMP 15 with NOP at 15 -> ovPC sequence 15 then 0.
REQ-036 iReset pulsed during WB of ADD -> rd and ovFlagsReg unchanged (0), state IDLE, all outputs 0.
REQ-037 iStart pulsed while oBusy -> PC and program flow unchanged; iStart in HALT -> FETCH at PC 0 with registers retained.
